// File: rtl/rv32i_wb_arbiter.sv
// Writeback arbiter: per-requester result FIFOs feeding one RF write port and the CDB.
// Round-robin selection among non-empty FIFOs; the winner is registered onto the outputs.
module rv32i_wb_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int FIFO_DEPTH  = 2,
  parameter int PHYS_IDX_BW = 6,
  parameter int DATA_BW     = 32,
  parameter int ROB_IDX_BW  = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  i_flush,
  input  logic [NUM_REQ-1:0]                    i_req_vld,
  output logic [NUM_REQ-1:0]                    o_req_rdy,
  input  logic [NUM_REQ-1:0]                    i_req_dst_vld,
  input  logic [NUM_REQ-1:0][PHYS_IDX_BW-1:0]   i_req_phys_idx,
  input  logic [NUM_REQ-1:0][DATA_BW-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0][ROB_IDX_BW-1:0]    i_req_rob_idx,
  output logic                                  o_rf_wen,
  output logic [PHYS_IDX_BW-1:0]                o_rf_wr_idx,
  output logic [DATA_BW-1:0]                    o_rf_wdata,
  output logic                                  o_cdb_vld,
  output logic                                  o_cdb_dst_vld,
  output logic [PHYS_IDX_BW-1:0]                o_cdb_phys_idx,
  output logic [DATA_BW-1:0]                    o_cdb_data,
  output logic [ROB_IDX_BW-1:0]                 o_cdb_rob_idx,
  output logic                                  o_idle
);

  localparam int PTR_BW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BW = $clog2(FIFO_DEPTH + 1);
  localparam int GNT_BW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic                   dst_vld;
    logic [PHYS_IDX_BW-1:0] phys_idx;
    logic [DATA_BW-1:0]     data;
    logic [ROB_IDX_BW-1:0]  rob_idx;
  } wb_entry_t;

  wb_entry_t          mem [NUM_REQ][FIFO_DEPTH];
  logic [PTR_BW-1:0]  wr_ptr [NUM_REQ];
  logic [PTR_BW-1:0]  rd_ptr [NUM_REQ];
  logic [CNT_BW-1:0]  count [NUM_REQ];
  logic [GNT_BW-1:0]  last_grant;

  wb_entry_t          entry_in [NUM_REQ];
  wb_entry_t          head [NUM_REQ];
  logic [NUM_REQ-1:0] not_empty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               grant_vld;
  logic [GNT_BW-1:0]  grant_idx;
  wb_entry_t          grant_entry;
  int                 cand;

  // Handshake: an entry transfers on a cycle where i_req_vld[i] and o_req_rdy[i]
  // are both high and i_flush is low; ready depends only on the registered count.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      not_empty[i] = (count[i] != '0);
      o_req_rdy[i] = (count[i] != CNT_BW'(FIFO_DEPTH));
      push[i]      = i_req_vld[i] & o_req_rdy[i] & ~i_flush;
      entry_in[i]  = '{dst_vld:  i_req_dst_vld[i],
                       phys_idx: i_req_phys_idx[i],
                       data:     i_req_data[i],
                       rob_idx:  i_req_rob_idx[i]};
      head[i]      = mem[i][rd_ptr[i]];
    end
  end

  // Search starts just past the previous winner, so every busy FIFO wins within NUM_REQ cycles.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_vld && not_empty[cand] && !i_flush) begin
        grant_vld = 1'b1;
        grant_idx = GNT_BW'(cand);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = grant_vld && (grant_idx == GNT_BW'(i));
    end
    grant_entry = head[grant_idx];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= entry_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      last_grant <= GNT_BW'(NUM_REQ - 1);
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_BW'(push[i]) - CNT_BW'(pop[i]);
      end
      if (grant_vld) last_grant <= grant_idx;
    end
  end

  // Index/data fields hold their last broadcast value when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_cdb_vld      <= 1'b0;
      o_cdb_dst_vld  <= 1'b0;
      o_cdb_phys_idx <= '0;
      o_cdb_data     <= '0;
      o_cdb_rob_idx  <= '0;
      o_rf_wen       <= 1'b0;
      o_rf_wr_idx    <= '0;
      o_rf_wdata     <= '0;
    end else begin
      o_cdb_vld <= grant_vld;
      o_rf_wen  <= grant_vld & grant_entry.dst_vld;
      if (grant_vld) begin
        o_cdb_dst_vld  <= grant_entry.dst_vld;
        o_cdb_phys_idx <= grant_entry.phys_idx;
        o_cdb_data     <= grant_entry.data;
        o_cdb_rob_idx  <= grant_entry.rob_idx;
        o_rf_wr_idx    <= grant_entry.phys_idx;
        o_rf_wdata     <= grant_entry.data;
      end
    end
  end

  assign o_idle = (not_empty == '0) & ~o_cdb_vld;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for rv32i_wb_arbiter: expected broadcasts queue up in grant order and
// a monitor compares every CDB beat; cycle-specific checks cover latency, ready, flush, reset.
module tb_rv32i_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int PB = 6;
  localparam int DB = 32;
  localparam int RB = 4;
  localparam int W = 1 + PB + DB + RB;

  logic                        clk = 1'b0;
  logic                        rstn = 1'b0;
  logic                        i_flush;
  logic [NUM_REQ-1:0]          i_req_vld;
  logic [NUM_REQ-1:0]          o_req_rdy;
  logic [NUM_REQ-1:0]          i_req_dst_vld;
  logic [NUM_REQ-1:0][PB-1:0]  i_req_phys_idx;
  logic [NUM_REQ-1:0][DB-1:0]  i_req_data;
  logic [NUM_REQ-1:0][RB-1:0]  i_req_rob_idx;
  logic                        o_rf_wen;
  logic [PB-1:0]               o_rf_wr_idx;
  logic [DB-1:0]               o_rf_wdata;
  logic                        o_cdb_vld;
  logic                        o_cdb_dst_vld;
  logic [PB-1:0]               o_cdb_phys_idx;
  logic [DB-1:0]               o_cdb_data;
  logic [RB-1:0]               o_cdb_rob_idx;
  logic                        o_idle;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rv32i_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_DEPTH(2), .PHYS_IDX_BW(PB), .DATA_BW(DB), .ROB_IDX_BW(RB)
  ) dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_dst_vld(i_req_dst_vld),
    .i_req_phys_idx(i_req_phys_idx), .i_req_data(i_req_data), .i_req_rob_idx(i_req_rob_idx),
    .o_rf_wen(o_rf_wen), .o_rf_wr_idx(o_rf_wr_idx), .o_rf_wdata(o_rf_wdata),
    .o_cdb_vld(o_cdb_vld), .o_cdb_dst_vld(o_cdb_dst_vld), .o_cdb_phys_idx(o_cdb_phys_idx),
    .o_cdb_data(o_cdb_data), .o_cdb_rob_idx(o_cdb_rob_idx), .o_idle(o_idle)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    i_flush        = 1'b0;
    i_req_vld      = '0;
    i_req_dst_vld  = '0;
    i_req_phys_idx = '0;
    i_req_data     = '0;
    i_req_rob_idx  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_req(input int r, input logic dst, input logic [PB-1:0] phys,
                         input logic [DB-1:0] data, input logic [RB-1:0] rob);
    i_req_vld[r]      = 1'b1;
    i_req_dst_vld[r]  = dst;
    i_req_phys_idx[r] = phys;
    i_req_data[r]     = data;
    i_req_rob_idx[r]  = rob;
  endtask

  task automatic expect_entry(input logic dst, input logic [PB-1:0] phys,
                              input logic [DB-1:0] data, input logic [RB-1:0] rob);
    exp_q.push_back({dst, phys, data, rob});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("idle_after_drain", 64'(o_idle), 64'(1));
    next_cycle();
  endtask

  // Scoreboard monitor
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (o_cdb_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cdb actual=rob%0d/phys%0d required=none at %0t",
                   o_cdb_rob_idx, o_cdb_phys_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_dst_vld", 64'(o_cdb_dst_vld), 64'(e[W-1]));
          chk("rf_wen", 64'(o_rf_wen), 64'(e[W-1]));
          chk("cdb_phys_idx", 64'(o_cdb_phys_idx), 64'(e[W-2 -: PB]));
          chk("rf_wr_idx", 64'(o_rf_wr_idx), 64'(e[W-2 -: PB]));
          chk("cdb_data", 64'(o_cdb_data), 64'(e[RB +: DB]));
          chk("rf_wdata", 64'(o_rf_wdata), 64'(e[RB +: DB]));
          chk("cdb_rob_idx", 64'(o_cdb_rob_idx), 64'(e[RB-1:0]));
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(o_req_rdy), 64'(3'b111));
    chk({tag, "_idle"}, 64'(o_idle), 64'(1));
    chk({tag, "_cdb_vld"}, 64'(o_cdb_vld), 64'(0));
    chk({tag, "_rf_wen"}, 64'(o_rf_wen), 64'(0));
    chk({tag, "_rf_wr_idx"}, 64'(o_rf_wr_idx), 64'(0));
    chk({tag, "_rf_wdata"}, 64'(o_rf_wdata), 64'(0));
    chk({tag, "_cdb_rob"}, 64'(o_cdb_rob_idx), 64'(0));
    chk({tag, "_cdb_phys"}, 64'(o_cdb_phys_idx), 64'(0));
  endtask

  initial begin
    clear_inputs();
    fork
      monitor();
    join_none
    do_reset();

    // Reset state, then single ALU result latency
    @(negedge clk);
    chk_reset_outputs("reset");
    next_cycle();
    set_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'd3);
    expect_entry(1'b1, 6'd5, 32'hDEADBEEF, 4'd3);
    next_cycle();
    @(negedge clk);
    chk("lat_c2_vld", 64'(o_cdb_vld), 64'(0));
    next_cycle();
    @(negedge clk);
    chk("lat_c3_vld", 64'(o_cdb_vld), 64'(1));
    chk("lat_c3_wen", 64'(o_rf_wen), 64'(1));
    next_cycle();
    @(negedge clk);
    chk("lat_c4_vld", 64'(o_cdb_vld), 64'(0));
    chk("lat_c4_wen", 64'(o_rf_wen), 64'(0));
    chk("lat_c4_idle", 64'(o_idle), 64'(1));
    next_cycle();

    // Simultaneous burst from all requesters, twice: order 0,1,2 both times
    do_reset();
    set_req(0, 1'b1, 6'd10, 32'h0000_0100, 4'd1);
    set_req(1, 1'b1, 6'd11, 32'h0000_0200, 4'd2);
    set_req(2, 1'b1, 6'd12, 32'h0000_0300, 4'd5);
    expect_entry(1'b1, 6'd10, 32'h0000_0100, 4'd1);
    expect_entry(1'b1, 6'd11, 32'h0000_0200, 4'd2);
    expect_entry(1'b1, 6'd12, 32'h0000_0300, 4'd5);
    next_cycle();
    @(negedge clk);
    chk("burst_c2_vld", 64'(o_cdb_vld), 64'(0));
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("burst_back_to_back_vld", 64'(o_cdb_vld), 64'(1));
      next_cycle();
    end
    set_req(0, 1'b1, 6'd20, 32'hA000_0000, 4'd8);
    set_req(1, 1'b1, 6'd21, 32'hB000_0000, 4'd9);
    set_req(2, 1'b1, 6'd22, 32'hC000_0000, 4'd10);
    expect_entry(1'b1, 6'd20, 32'hA000_0000, 4'd8);
    expect_entry(1'b1, 6'd21, 32'hB000_0000, 4'd9);
    expect_entry(1'b1, 6'd22, 32'hC000_0000, 4'd10);
    next_cycle();
    wait_drain();

    // LSU backpressure under ALU/branch traffic
    do_reset();
    expect_entry(1'b1, 6'd30, 32'h1111_0000, 4'd0);  // L0
    expect_entry(1'b1, 6'd40, 32'h2222_0000, 4'd1);  // B0
    expect_entry(1'b1, 6'd50, 32'h3333_0000, 4'd2);  // A0
    expect_entry(1'b1, 6'd31, 32'h1111_0001, 4'd3);  // L1
    expect_entry(1'b1, 6'd41, 32'h2222_0001, 4'd4);  // B1
    expect_entry(1'b1, 6'd51, 32'h3333_0001, 4'd5);  // A1
    expect_entry(1'b1, 6'd32, 32'h1111_0002, 4'd6);  // L2
    expect_entry(1'b1, 6'd42, 32'h2222_0002, 4'd7);  // B2
    set_req(1, 1'b1, 6'd30, 32'h1111_0000, 4'd0);
    next_cycle();
    set_req(0, 1'b1, 6'd50, 32'h3333_0000, 4'd2);
    set_req(2, 1'b1, 6'd40, 32'h2222_0000, 4'd1);
    next_cycle();
    set_req(0, 1'b1, 6'd51, 32'h3333_0001, 4'd5);
    set_req(1, 1'b1, 6'd31, 32'h1111_0001, 4'd3);
    set_req(2, 1'b1, 6'd41, 32'h2222_0001, 4'd4);
    next_cycle();
    set_req(1, 1'b1, 6'd32, 32'h1111_0002, 4'd6);
    set_req(2, 1'b1, 6'd42, 32'h2222_0002, 4'd7);
    @(negedge clk);
    chk("bp_c3_rdy", 64'(o_req_rdy), 64'(3'b110));
    next_cycle();
    @(negedge clk);
    chk("bp_c4_rdy_lsu_full", 64'(o_req_rdy), 64'(3'b001));
    next_cycle();
    @(negedge clk);
    chk("bp_c5_rdy_lsu_back", 64'(o_req_rdy), 64'(3'b011));
    next_cycle();
    wait_drain();

    // Branch result without a destination register
    do_reset();
    set_req(2, 1'b0, 6'd9, 32'h0000_0055, 4'd7);
    expect_entry(1'b0, 6'd9, 32'h0000_0055, 4'd7);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("nodst_cdb_vld", 64'(o_cdb_vld), 64'(1));
    chk("nodst_rf_wen", 64'(o_rf_wen), 64'(0));
    next_cycle();
    wait_drain();

    // Flush with buffered entries and a simultaneous push
    do_reset();
    set_req(0, 1'b1, 6'd1, 32'h0F0F_0001, 4'd1);
    set_req(1, 1'b1, 6'd2, 32'h0F0F_0002, 4'd2);
    set_req(2, 1'b1, 6'd3, 32'h0F0F_0003, 4'd3);
    expect_entry(1'b1, 6'd1, 32'h0F0F_0001, 4'd1);
    next_cycle();
    set_req(0, 1'b1, 6'd4, 32'h0F0F_0004, 4'd4);
    set_req(1, 1'b1, 6'd5, 32'h0F0F_0005, 4'd5);
    set_req(2, 1'b1, 6'd6, 32'h0F0F_0006, 4'd6);
    next_cycle();
    i_flush = 1'b1;
    set_req(0, 1'b1, 6'd7, 32'h0F0F_0007, 4'd7);
    @(negedge clk);
    chk("flush_cycle_vld", 64'(o_cdb_vld), 64'(1));
    next_cycle();
    @(negedge clk);
    chk("flush_p1_vld", 64'(o_cdb_vld), 64'(0));
    chk("flush_p1_wen", 64'(o_rf_wen), 64'(0));
    chk("flush_p1_rdy", 64'(o_req_rdy), 64'(3'b111));
    next_cycle();
    @(negedge clk);
    chk("flush_p2_idle", 64'(o_idle), 64'(1));
    next_cycle();
    repeat (6) next_cycle();
    chk("flush_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset mid-burst with four buffered entries
    do_reset();
    set_req(0, 1'b1, 6'd33, 32'h5A5A_0001, 4'd11);
    set_req(1, 1'b1, 6'd34, 32'h5A5A_0002, 4'd12);
    set_req(2, 1'b1, 6'd35, 32'h5A5A_0003, 4'd13);
    expect_entry(1'b1, 6'd33, 32'h5A5A_0001, 4'd11);
    next_cycle();
    set_req(0, 1'b1, 6'd36, 32'h5A5A_0004, 4'd14);
    set_req(1, 1'b1, 6'd37, 32'h5A5A_0005, 4'd15);
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (8) next_cycle();
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
